fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the SOIN-RV pipeline. It resolves operand forwarding for any number of EX-stage read ports from any number of downstream write stages, ordered youngest to oldest. It also forwards store data. A scoreboard tracks in-flight long-latency writes (loads, mul/div) and stalls EX while a dependent operand is not yet forwardable. It sits beside the EX stage and drives the EX operand muxes and the pipeline stall/hold logic.

## Interface
- NUM_RPORTS, 2, EX read ports.
- NUM_FWD_STAGES, 2, forwarding source stages; index 0 = MEM (youngest), 1 = WB, ...
- REG_ADDR_W, 5, register number width.
- MAX_PENDING, 4, scoreboard entries.
- LAT_W, 3, latency counter width.
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_ex_valid  in  1  EX holds a valid instruction.
- i_ex_rnum  in  NUM_RPORTS x REG_ADDR_W  EX source registers.
- i_ex_ren  in  NUM_RPORTS  source register is actually read.
- i_stg_wnum  in  NUM_FWD_STAGES x REG_ADDR_W  destination register per stage.
- i_stg_wen  in  NUM_FWD_STAGES  register write enable per stage.
- i_mem_store  in  1  MEM holds a store.
- i_lng_issue  in  1  EX issues a long-latency write this cycle.
- i_lng_wnum  in  REG_ADDR_W  its destination.
- i_lng_lat  in  LAT_W  cycles until its result is visible at stage 0.
- i_flush  in  1  kill all in-flight long-latency ops.
- o_fwd_sel  out  NUM_RPORTS x SEL_W  per port: 0 = register file, k = stage k-1. SEL_W = $clog2(NUM_FWD_STAGES+1).
- o_st_fwd  out  1  store data taken from last stage (WB) instead of MEM operand.
- o_stall  out  1  hold EX and earlier stages.
- o_sb_full  out  1  no free scoreboard entry.
- o_sb_count  out  $clog2(MAX_PENDING+1)  valid entries.

## Operation
- **Forwarding (combinational):**
  - Port p matches stage s when i_ex_ren[p], i_stg_wen[s], i_stg_wnum[s]==i_ex_rnum[p] and rnum!=0.
  - The lowest matching s wins; o_fwd_sel[p]=s+1, else 0.
- **Store forwarding:** o_st_fwd=1 when i_mem_store and the last stage writes a nonzero register equal to i_ex_rnum[1]. This generalises the existing MEM/WB store case.
- **Scoreboard entry:** {valid, wnum, cnt}.
- **Allocation:**
  - Allocation occurs when i_lng_issue, !o_sb_full, !o_stall, i_lng_wnum!=0 and i_lng_lat!=0.
  - The lowest-index free entry is used, with cnt=i_lng_lat.
  - lat=0 or wnum=0 allocates nothing.
- **Ageing:**
  - Every cycle, each valid entry with cnt>1 decrements.
  - An entry with cnt==1 clears; its result is then covered by stage-0 forwarding.
- **Stall:** o_stall=1 when either:
  - i_ex_valid and any enabled port with rnum!=0 matches a valid entry, or
  - i_lng_issue and o_sb_full.
- **WAW:** duplicate wnum entries are allowed and tracked independently.
- **Flush:** synchronously clears every entry. Flush has priority over a same-cycle allocation, which is dropped.
- **Full:** o_sb_full is computed from registered state. An issue on a cycle where an entry is retiring is still rejected.

## Timing
- Reset (i_rstn=0, asynchronous):
  - all entries invalid, o_sb_count=0, o_sb_full=0;
  - o_stall, o_fwd_sel and o_st_fwd depend only on inputs and empty state.
- Forwarding, stall and full outputs are combinational from inputs and registered state. No latency.
- Scoreboard updates on the rising i_clk edge.
- An issue with lat=L stalls a dependent in EX for exactly L cycles after the issue cycle. The dependent then sees o_fwd_sel=1 if stage 0 carries the write.
- Reset asserted mid-operation drops all entries immediately.

## Structure
- Package fwd_pkg holds:
  - reg_t (logic [REG_ADDR_W-1:0]);
  - sb_entry_t struct;
  - FWD_SEL_RF=0 constant.
- Sub-module fwd_scoreboard (entries, allocation, ageing, flush, count, match vector). The top level holds the forwarding priority encoders and the stall OR.

## Test plan
- Stage0 wnum=5 wen, stage1 wnum=5 wen, port0 rnum=5 → o_fwd_sel[0]=1. Drop stage0 wen → 2. Set rnum=0 → 0.
- Last-stage write x7, i_mem_store=1, port1 rnum=7 → o_st_fwd=1; with i_mem_store=0 → 0.
- Issue wnum=9 lat=3, then hold dependent rnum=9 in EX:
  - o_stall=1 for 3 cycles, then 0;
  - o_sb_count sequence 1,1,1,0.
- Issue 4 ops lat=7 → o_sb_full=1. A fifth issue → o_stall=1 and count stays 4.
- With 2 entries valid, assert i_flush together with i_lng_issue → count 0 next cycle and no entry allocated.
- With 3 entries valid, assert i_rstn=0 asynchronously between edges → count 0 and o_sb_full=0 immediately.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit.
// Scoreboard entry layout and register number type.
package fwd_pkg;

  localparam int REG_W = 5;
  localparam int CNT_BITS = 3;
  localparam int FWD_SEL_RF = 0;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  typedef struct packed {
    logic valid;
    reg_t wnum;
    cnt_t cnt;
  } sb_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-side bundle between the pipeline and the
// forwarding/hazard unit.
interface fwd_hazard_unit_if #(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_PENDING = 4,
  parameter int LAT_W = 3
);

  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic i_ex_valid;
  logic [NUM_RPORTS-1:0][REG_ADDR_W-1:0] i_ex_rnum;
  logic [NUM_RPORTS-1:0] i_ex_ren;
  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] i_stg_wnum;
  logic [NUM_FWD_STAGES-1:0] i_stg_wen;
  logic i_mem_store;
  logic i_lng_issue;
  logic [REG_ADDR_W-1:0] i_lng_wnum;
  logic [LAT_W-1:0] i_lng_lat;
  logic i_flush;
  logic [NUM_RPORTS-1:0][SEL_W-1:0] o_fwd_sel;
  logic o_st_fwd;
  logic o_stall;
  logic o_sb_full;
  logic [CNT_W-1:0] o_sb_count;

  modport master (
    output i_ex_valid, i_ex_rnum, i_ex_ren,
    output i_stg_wnum, i_stg_wen, i_mem_store,
    output i_lng_issue, i_lng_wnum, i_lng_lat,
    output i_flush,
    input  o_fwd_sel, o_st_fwd, o_stall,
    input  o_sb_full, o_sb_count
  );

  modport slave (
    input  i_ex_valid, i_ex_rnum, i_ex_ren,
    input  i_stg_wnum, i_stg_wen, i_mem_store,
    input  i_lng_issue, i_lng_wnum, i_lng_lat,
    input  i_flush,
    output o_fwd_sel, o_st_fwd, o_stall,
    output o_sb_full, o_sb_count
  );

endinterface

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight long-latency writes and reports
// which EX read ports depend on one of them.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_RPORTS = 2,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_flush,
  input  logic i_alloc,
  input  reg_t i_wnum,
  input  cnt_t i_lat,
  input  reg_t [NUM_RPORTS-1:0] i_rnum,
  input  logic [NUM_RPORTS-1:0] i_ren,
  output logic [NUM_RPORTS-1:0] o_match,
  output logic o_full,
  output logic [CNT_W-1:0] o_count
);

  sb_entry_t sb_q [MAX_PENDING];
  sb_entry_t sb_d [MAX_PENDING];
  logic placed;

  // Retiring entries are not reusable until the next cycle.
  always_comb begin
    placed = 1'b0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      sb_d[i] = sb_q[i];
      if (sb_q[i].valid) begin
        if (sb_q[i].cnt > cnt_t'(1))
          sb_d[i].cnt = sb_q[i].cnt - cnt_t'(1);
        else
          sb_d[i] = '0;
      end
      if (i_alloc && !placed && !sb_q[i].valid) begin
        sb_d[i].valid = 1'b1;
        sb_d[i].wnum = i_wnum;
        sb_d[i].cnt = i_lat;
        placed = 1'b1;
      end
      if (i_flush)
        sb_d[i] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < MAX_PENDING; i++)
        sb_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_PENDING; i++)
        sb_q[i] <= sb_d[i];
    end
  end

  always_comb begin
    o_count = '0;
    o_full = 1'b1;
    for (int i = 0; i < MAX_PENDING; i++) begin
      o_count = o_count + CNT_W'(sb_q[i].valid);
      o_full = o_full & sb_q[i].valid;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      o_match[p] = 1'b0;
      for (int i = 0; i < MAX_PENDING; i++)
        if (sb_q[i].valid && sb_q[i].wnum == i_rnum[p])
          o_match[p] = 1'b1;
      o_match[p] = o_match[p] & i_ren[p]
                 & (i_rnum[p] != '0);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand/store forwarding select and EX stall for
// the SOIN-RV pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W = REG_W,
  parameter int MAX_PENDING = 4,
  parameter int LAT_W = CNT_BITS
) (
  input logic i_clk,
  input logic i_rstn,
  fwd_hazard_unit_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int LAST = NUM_FWD_STAGES - 1;
  localparam int ST_PORT = (NUM_RPORTS > 1) ? 1 : 0;

  logic [NUM_RPORTS-1:0] sb_match;
  logic sb_full;
  logic [CNT_W-1:0] sb_count;
  logic stall;
  logic alloc;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      bus.o_fwd_sel[p] = SEL_W'(FWD_SEL_RF);
      for (int s = NUM_FWD_STAGES - 1; s >= 0; s--)
        if (bus.i_ex_ren[p] && bus.i_stg_wen[s]
            && bus.i_stg_wnum[s] == bus.i_ex_rnum[p]
            && bus.i_ex_rnum[p] != '0)
          bus.o_fwd_sel[p] = SEL_W'(s + 1);
    end
  end

  assign bus.o_st_fwd = bus.i_mem_store
    && bus.i_stg_wen[LAST]
    && bus.i_stg_wnum[LAST] != '0
    && bus.i_stg_wnum[LAST] == bus.i_ex_rnum[ST_PORT];

  assign stall = (bus.i_ex_valid && |sb_match)
               || (bus.i_lng_issue && sb_full);

  assign alloc = bus.i_lng_issue && !sb_full && !stall
               && bus.i_lng_wnum != '0
               && bus.i_lng_lat != '0;

  fwd_scoreboard #(
    .NUM_RPORTS (NUM_RPORTS),
    .MAX_PENDING(MAX_PENDING),
    .CNT_W      (CNT_W)
  ) u_sb (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_flush(bus.i_flush),
    .i_alloc(alloc),
    .i_wnum (bus.i_lng_wnum),
    .i_lat  (bus.i_lng_lat),
    .i_rnum (bus.i_ex_rnum),
    .i_ren  (bus.i_ex_ren),
    .o_match(sb_match),
    .o_full (sb_full),
    .o_count(sb_count)
  );

  assign bus.o_stall = stall;
  assign bus.o_sb_full = sb_full;
  assign bus.o_sb_count = sb_count;

endmodule
